mem_arbiter: RTL and testbench

Two-port memory arbiter and access sequencer for the LC-3b core. Shares the single Memory block between the CPU's MAR/MDR access path and a second requester (DMA/debug loader). It serialises their requests, drives the memory address, data, size and write lines for a fixed access latency, and returns read data with a one-cycle acknowledge pulse.

---
 rtl/lc3b_mem_pkg.sv | 30 +++
 rtl/mem_arb_pick.sv | 34 +++
 rtl/mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_mem_pkg.sv
// lc3b_mem_pkg -- shared definitions for the LC-3b memory arbiter.
//   state_t / ST_*   : arbiter FSM state encoding (IDLE, ACCESS, DONE)
//   SIZE_BYTE/WORD   : access size encoding on *_size and mem_size
//   OWN_CPU/OWN_DMA  : owner encoding for the granted port and last_grant
//   MEM_LAT_MAX      : largest supported memory access latency
//   access_addr()    : address presented to Memory for a given size
package lc3b_mem_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCESS = 2'd1;
  localparam state_t ST_DONE   = 2'd2;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  localparam int MEM_LAT_MAX = 15;

  // Word accesses always address the even byte; bytes pass through and
  // Memory picks the lane from addr[0].
  function automatic logic [15:0] access_addr(input logic [15:0] addr,
                                              input logic        size);
    access_addr = (size == SIZE_WORD) ? {addr[15:1], 1'b0} : addr;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick -- combinational grant selection between CPU and DMA.
//   CPU_PRIO    : 1 = CPU wins ties, 0 = alternate against last_grant
//   cpu_req     : CPU request
//   dma_req     : DMA request
//   last_grant  : owner of the previous completed transfer
//   grant_vld   : at least one request present
//   grant_own   : owner to grant (OWN_CPU / OWN_DMA), valid with grant_vld
module mem_arb_pick
  import lc3b_mem_pkg::*;
#(
  parameter int CPU_PRIO = 1
) (
  input  logic cpu_req,
  input  logic dma_req,
  input  logic last_grant,
  output logic grant_vld,
  output logic grant_own
);

  always_comb begin
    grant_vld = cpu_req | dma_req;
    grant_own = OWN_CPU;
    if (cpu_req && dma_req) begin
      if (CPU_PRIO != 0) begin
        grant_own = OWN_CPU;
      end else begin
        grant_own = (last_grant == OWN_CPU) ? OWN_DMA : OWN_CPU;
      end
    end else if (dma_req) begin
      grant_own = OWN_DMA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter -- two-port (CPU / DMA) arbiter and access sequencer in
// front of the single LC-3b Memory block.
//   MEM_LAT   : memory access cycles per transfer (1..MEM_LAT_MAX)
//   CPU_PRIO  : 1 = CPU wins ties, 0 = round-robin
//   clk, reset                 : clock, synchronous active-high reset
//   cpu_req/write/size/addr/wdata : CPU request, held until cpu_ack
//   cpu_ack, cpu_rdata, cpu_err   : completion pulse, read data, misalign
//   dma_*                      : same set for the DMA / debug loader port
//   mem_en, mem_write, mem_size, mem_addr, mem_wdata : Memory drive
//   mem_rdata                  : Memory read data
// Build option: define MEM_ARB_ALIGN_CHECK_EN to reject odd-address word
// accesses with err=1 instead of forcing the address even.
module mem_arbiter
  import lc3b_mem_pkg::*;
#(
  parameter int MEM_LAT  = 2,
  parameter int CPU_PRIO = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_write,
  input  logic        cpu_size,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [15:0] cpu_rdata,
  output logic        cpu_err,
  input  logic        dma_req,
  input  logic        dma_write,
  input  logic        dma_size,
  input  logic [15:0] dma_addr,
  input  logic [15:0] dma_wdata,
  output logic        dma_ack,
  output logic [15:0] dma_rdata,
  output logic        dma_err,
  output logic        mem_en,
  output logic        mem_write,
  output logic        mem_size,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  // Out-of-range latencies are clamped rather than wrapping the counter.
  localparam int LAT_EFF = (MEM_LAT < 1) ? 1 :
                           (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;
  localparam logic [3:0] CNT_LOAD = 4'(LAT_EFF - 1);

  state_t      state;
  logic        own;
  logic        last_grant;
  logic [3:0]  cnt;
  logic        lat_write;
  logic        lat_size;
  logic [15:0] lat_addr;
  logic [15:0] lat_wdata;
  logic        lat_err;
  logic [15:0] cpu_rdata_r;
  logic [15:0] dma_rdata_r;

  logic        grant_vld;
  logic        grant_own;
  logic        sel_write;
  logic        sel_size;
  logic [15:0] sel_addr;
  logic [15:0] sel_wdata;
  logic        sel_misalign;

  mem_arb_pick #(
    .CPU_PRIO (CPU_PRIO)
  ) u_pick (
    .cpu_req    (cpu_req),
    .dma_req    (dma_req),
    .last_grant (last_grant),
    .grant_vld  (grant_vld),
    .grant_own  (grant_own)
  );

  assign sel_write = (grant_own == OWN_CPU) ? cpu_write : dma_write;
  assign sel_size  = (grant_own == OWN_CPU) ? cpu_size  : dma_size;
  assign sel_addr  = (grant_own == OWN_CPU) ? cpu_addr  : dma_addr;
  assign sel_wdata = (grant_own == OWN_CPU) ? cpu_wdata : dma_wdata;

`ifdef MEM_ARB_ALIGN_CHECK_EN
  assign sel_misalign = (sel_size == SIZE_WORD) && sel_addr[0];
`else
  // Without the check lat_err never sets, so both err outputs stay 0.
  assign sel_misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      last_grant  <= OWN_DMA;
      own         <= OWN_CPU;
      cnt         <= 4'd0;
      lat_write   <= 1'b0;
      lat_size    <= 1'b0;
      lat_addr    <= 16'h0000;
      lat_wdata   <= 16'h0000;
      lat_err     <= 1'b0;
      cpu_rdata_r <= 16'h0000;
      dma_rdata_r <= 16'h0000;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_vld) begin
            own       <= grant_own;
            lat_write <= sel_write;
            lat_size  <= sel_size;
            lat_addr  <= access_addr(sel_addr, sel_size);
            lat_wdata <= sel_wdata;
            lat_err   <= sel_misalign;
            cnt       <= CNT_LOAD;
            if (sel_misalign) begin
              // Rejected access: no Memory cycle, owner sees rdata 0.
              state <= ST_DONE;
              if (grant_own == OWN_CPU) begin
                cpu_rdata_r <= 16'h0000;
              end else begin
                dma_rdata_r <= 16'h0000;
              end
            end else begin
              state <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          if (cnt == 4'd0) begin
            if (!lat_write) begin
              if (own == OWN_CPU) begin
                cpu_rdata_r <= mem_rdata;
              end else begin
                dma_rdata_r <= mem_rdata;
              end
            end
            state <= ST_DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_DONE: begin
          last_grant <= own;
          state      <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_en    = (state == ST_ACCESS);
  assign mem_write = mem_en & lat_write;
  assign mem_size  = lat_size;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;

  assign cpu_ack   = (state == ST_DONE) && (own == OWN_CPU);
  assign dma_ack   = (state == ST_DONE) && (own == OWN_DMA);
  assign cpu_err   = cpu_ack & lat_err;
  assign dma_err   = dma_ack & lat_err;
  assign cpu_rdata = cpu_rdata_r;
  assign dma_rdata = dma_rdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- directed bench for mem_arbiter.
//   u_a : MEM_LAT=2, CPU_PRIO=1 (read, priority tie, byte write, misalign)
//   u_b : MEM_LAT=4, CPU_PRIO=0 (round-robin, reset during ACCESS)
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // DUT A signals
  logic        a_cpu_req, a_cpu_write, a_cpu_size;
  logic [15:0] a_cpu_addr, a_cpu_wdata;
  logic        a_cpu_ack, a_cpu_err;
  logic [15:0] a_cpu_rdata;
  logic        a_dma_req, a_dma_write, a_dma_size;
  logic [15:0] a_dma_addr, a_dma_wdata;
  logic        a_dma_ack, a_dma_err;
  logic [15:0] a_dma_rdata;
  logic        a_mem_en, a_mem_write, a_mem_size;
  logic [15:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

  // DUT B signals
  logic        b_cpu_req, b_cpu_write, b_cpu_size;
  logic [15:0] b_cpu_addr, b_cpu_wdata;
  logic        b_cpu_ack, b_cpu_err;
  logic [15:0] b_cpu_rdata;
  logic        b_dma_req, b_dma_write, b_dma_size;
  logic [15:0] b_dma_addr, b_dma_wdata;
  logic        b_dma_ack, b_dma_err;
  logic [15:0] b_dma_rdata;
  logic        b_mem_en, b_mem_write, b_mem_size;
  logic [15:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.MEM_LAT(2), .CPU_PRIO(1)) u_a (
    .clk(clk), .reset(reset),
    .cpu_req(a_cpu_req), .cpu_write(a_cpu_write), .cpu_size(a_cpu_size),
    .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata), .cpu_ack(a_cpu_ack),
    .cpu_rdata(a_cpu_rdata), .cpu_err(a_cpu_err),
    .dma_req(a_dma_req), .dma_write(a_dma_write), .dma_size(a_dma_size),
    .dma_addr(a_dma_addr), .dma_wdata(a_dma_wdata), .dma_ack(a_dma_ack),
    .dma_rdata(a_dma_rdata), .dma_err(a_dma_err),
    .mem_en(a_mem_en), .mem_write(a_mem_write), .mem_size(a_mem_size),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );

  mem_arbiter #(.MEM_LAT(4), .CPU_PRIO(0)) u_b (
    .clk(clk), .reset(reset),
    .cpu_req(b_cpu_req), .cpu_write(b_cpu_write), .cpu_size(b_cpu_size),
    .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata), .cpu_ack(b_cpu_ack),
    .cpu_rdata(b_cpu_rdata), .cpu_err(b_cpu_err),
    .dma_req(b_dma_req), .dma_write(b_dma_write), .dma_size(b_dma_size),
    .dma_addr(b_dma_addr), .dma_wdata(b_dma_wdata), .dma_ack(b_dma_ack),
    .dma_rdata(b_dma_rdata), .dma_err(b_dma_err),
    .mem_en(b_mem_en), .mem_write(b_mem_write), .mem_size(b_mem_size),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    a_cpu_req = 0; a_cpu_write = 0; a_cpu_size = 0; a_cpu_addr = 0; a_cpu_wdata = 0;
    a_dma_req = 0; a_dma_write = 0; a_dma_size = 0; a_dma_addr = 0; a_dma_wdata = 0;
    a_mem_rdata = 16'h0000;
    b_cpu_req = 0; b_cpu_write = 0; b_cpu_size = 0; b_cpu_addr = 0; b_cpu_wdata = 0;
    b_dma_req = 0; b_dma_write = 0; b_dma_size = 0; b_dma_addr = 0; b_dma_wdata = 0;
    b_mem_rdata = 16'h0000;

    // ---------------- reset state ----------------
    step(); step();
    check("rst a_cpu_ack",   {15'd0, a_cpu_ack},   16'd0);
    check("rst a_dma_ack",   {15'd0, a_dma_ack},   16'd0);
    check("rst a_cpu_err",   {15'd0, a_cpu_err},   16'd0);
    check("rst a_mem_en",    {15'd0, a_mem_en},    16'd0);
    check("rst a_mem_write", {15'd0, a_mem_write}, 16'd0);
    check("rst a_mem_size",  {15'd0, a_mem_size},  16'd0);
    check("rst a_mem_addr",  a_mem_addr,  16'h0000);
    check("rst a_mem_wdata", a_mem_wdata, 16'h0000);
    check("rst a_cpu_rdata", a_cpu_rdata, 16'h0000);
    check("rst a_dma_rdata", a_dma_rdata, 16'h0000);
    check("rst b_mem_en",    {15'd0, b_mem_en},    16'd0);
    check("rst b_dma_err",   {15'd0, b_dma_err},   16'd0);
    reset = 1'b0;
    step();

    // ---------------- CPU word read, MEM_LAT=2 ----------------
    a_mem_rdata = 16'hBEEF;
    a_cpu_req = 1; a_cpu_write = 0; a_cpu_size = 1; a_cpu_addr = 16'h3000;
    step(); // cycle 1
    check("rd c1 mem_en",    {15'd0, a_mem_en},    16'd1);
    check("rd c1 mem_addr",  a_mem_addr,           16'h3000);
    check("rd c1 mem_write", {15'd0, a_mem_write}, 16'd0);
    check("rd c1 mem_size",  {15'd0, a_mem_size},  16'd1);
    check("rd c1 cpu_ack",   {15'd0, a_cpu_ack},   16'd0);
    step(); // cycle 2
    check("rd c2 mem_en",    {15'd0, a_mem_en},    16'd1);
    step(); // cycle 3
    check("rd c3 cpu_ack",   {15'd0, a_cpu_ack},   16'd1);
    check("rd c3 cpu_rdata", a_cpu_rdata,          16'hBEEF);
    check("rd c3 cpu_err",   {15'd0, a_cpu_err},   16'd0);
    check("rd c3 mem_en",    {15'd0, a_mem_en},    16'd0);
    check("rd c3 dma_ack",   {15'd0, a_dma_ack},   16'd0);
    a_cpu_req = 0;
    step(); // cycle 4
    check("rd c4 cpu_ack",   {15'd0, a_cpu_ack},   16'd0);
    check("rd c4 rdata hold", a_cpu_rdata,         16'hBEEF);
    check("rd c4 mem_en",    {15'd0, a_mem_en},    16'd0);

    // ---------------- simultaneous requests, CPU priority ----------------
    a_mem_rdata = 16'h1111;
    a_cpu_req = 1; a_cpu_write = 0; a_cpu_size = 1; a_cpu_addr = 16'h1234;
    a_dma_req = 1; a_dma_write = 0; a_dma_size = 1; a_dma_addr = 16'h5678;
    step(); // cycle 1
    check("pri c1 mem_addr", a_mem_addr, 16'h1234);
    step(); // cycle 2
    step(); // cycle 3
    check("pri c3 cpu_ack",  {15'd0, a_cpu_ack}, 16'd1);
    check("pri c3 dma_ack",  {15'd0, a_dma_ack}, 16'd0);
    check("pri c3 cpu_rdata", a_cpu_rdata,       16'h1111);
    a_cpu_req = 0;
    a_mem_rdata = 16'h2222;
    step(); // cycle 4: IDLE, DMA granted
    check("pri c4 mem_en",   {15'd0, a_mem_en},  16'd0);
    check("pri c4 dma_ack",  {15'd0, a_dma_ack}, 16'd0);
    step(); // cycle 5
    check("pri c5 mem_en",   {15'd0, a_mem_en},  16'd1);
    check("pri c5 mem_addr", a_mem_addr,         16'h5678);
    step(); // cycle 6
    check("pri c6 dma_ack",  {15'd0, a_dma_ack}, 16'd0);
    step(); // cycle 7
    check("pri c7 dma_ack",  {15'd0, a_dma_ack}, 16'd1);
    check("pri c7 cpu_ack",  {15'd0, a_cpu_ack}, 16'd0);
    check("pri c7 dma_rdata", a_dma_rdata,       16'h2222);
    check("pri c7 cpu_rdata", a_cpu_rdata,       16'h1111);
    a_dma_req = 0;
    step();

    // ---------------- DMA byte write ----------------
    a_mem_rdata = 16'h7777;
    a_dma_req = 1; a_dma_write = 1; a_dma_size = 0;
    a_dma_addr = 16'h4001; a_dma_wdata = 16'h00A5;
    for (int c = 1; c <= 2; c++) begin
      step();
      check("bw mem_en",    {15'd0, a_mem_en},    16'd1);
      check("bw mem_write", {15'd0, a_mem_write}, 16'd1);
      check("bw mem_size",  {15'd0, a_mem_size},  16'd0);
      check("bw mem_addr",  a_mem_addr,           16'h4001);
      check("bw mem_wdata", a_mem_wdata,          16'h00A5);
    end
    step();
    check("bw dma_ack",   {15'd0, a_dma_ack},   16'd1);
    check("bw dma_err",   {15'd0, a_dma_err},   16'd0);
    check("bw mem_write", {15'd0, a_mem_write}, 16'd0);
    check("bw rdata kept", a_dma_rdata,         16'h2222);
    a_dma_req = 0; a_dma_write = 0;
    step();

    // ---------------- misaligned CPU word read ----------------
    a_mem_rdata = 16'h3333;
    a_cpu_req = 1; a_cpu_write = 0; a_cpu_size = 1; a_cpu_addr = 16'h2001;
    step(); // cycle 1
`ifdef MEM_ARB_ALIGN_CHECK_EN
    check("mis c1 mem_en",    {15'd0, a_mem_en},  16'd0);
    check("mis c1 cpu_ack",   {15'd0, a_cpu_ack}, 16'd1);
    check("mis c1 cpu_err",   {15'd0, a_cpu_err}, 16'd1);
    check("mis c1 cpu_rdata", a_cpu_rdata,        16'h0000);
    a_cpu_req = 0;
    step();
    check("mis c2 cpu_ack",   {15'd0, a_cpu_ack}, 16'd0);
`else
    check("mis c1 mem_en",    {15'd0, a_mem_en},  16'd1);
    check("mis c1 mem_addr",  a_mem_addr,         16'h2000);
    step(); // cycle 2
    step(); // cycle 3
    check("mis c3 cpu_ack",   {15'd0, a_cpu_ack}, 16'd1);
    check("mis c3 cpu_err",   {15'd0, a_cpu_err}, 16'd0);
    check("mis c3 cpu_rdata", a_cpu_rdata,        16'h3333);
    a_cpu_req = 0;
    step();
`endif
    step();

    // ---------------- round-robin on u_b, four transfers ----------------
    b_mem_rdata = 16'hCAFE;
    b_cpu_req = 1; b_cpu_write = 0; b_cpu_size = 1; b_cpu_addr = 16'h0100;
    b_dma_req = 1; b_dma_write = 0; b_dma_size = 1; b_dma_addr = 16'h0200;
    for (int t = 0; t < 4; t++) begin
      logic exp_cpu;
      exp_cpu = ((t % 2) == 0);
      step(); // first ACCESS cycle
      check("rr mem_en",   {15'd0, b_mem_en}, 16'd1);
      check("rr mem_addr", b_mem_addr, exp_cpu ? 16'h0100 : 16'h0200);
      step(); step(); step();
      check("rr last mem_en", {15'd0, b_mem_en}, 16'd1);
      step(); // DONE
      check("rr cpu_ack", {15'd0, b_cpu_ack}, {15'd0, exp_cpu});
      check("rr dma_ack", {15'd0, b_dma_ack}, {15'd0, ~exp_cpu});
      if (t == 3) begin
        b_cpu_req = 0;
        b_dma_req = 0;
      end
      step(); // IDLE
    end
    check("rr cpu_rdata", b_cpu_rdata, 16'hCAFE);
    check("rr dma_rdata", b_dma_rdata, 16'hCAFE);
    step();

    // ---------------- reset during ACCESS, MEM_LAT=4 ----------------
    b_mem_rdata = 16'h9999;
    b_cpu_req = 1; b_cpu_write = 1; b_cpu_size = 1;
    b_cpu_addr = 16'h0300; b_cpu_wdata = 16'h5A5A;
    step(); // ACCESS cycle 1
    check("rstacc c1 mem_en", {15'd0, b_mem_en}, 16'd1);
    reset = 1'b1;
    step();
    check("rstacc mem_en",    {15'd0, b_mem_en},    16'd0);
    check("rstacc mem_write", {15'd0, b_mem_write}, 16'd0);
    check("rstacc mem_addr",  b_mem_addr,           16'h0000);
    check("rstacc mem_wdata", b_mem_wdata,          16'h0000);
    check("rstacc cpu_rdata", b_cpu_rdata,          16'h0000);
    check("rstacc cpu_ack",   {15'd0, b_cpu_ack},   16'd0);
    reset = 1'b0;
    b_cpu_req = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      check("rstacc no ack", {15'd0, b_cpu_ack}, 16'd0);
      check("rstacc idle",   {15'd0, b_mem_en},  16'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case the directed sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
